// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides and registered result/flags.
// Multiply (shift-add) and divide (restoring) iterate one bit per clock; all other ops take one cycle.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6,
  parameter int DIV_ENABLE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [OPRN_WIDTH-1:0] oprn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  zero,
  output logic                  ovf,
  output logic                  err
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int MSB     = DATA_WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OP_SHR = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OP_SHL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);
  localparam logic [OPRN_WIDTH-1:0] OP_DIV = OPRN_WIDTH'(10);
  localparam logic [OPRN_WIDTH-1:0] OP_REM = OPRN_WIDTH'(11);

  localparam logic [DATA_WIDTH-1:0] DW_V = DATA_WIDTH'(DATA_WIDTH);
  localparam logic [SHAMT_W-1:0]    LAST = SHAMT_W'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic                  rst_done;
  logic [SHAMT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;
  logic [DATA_WIDTH-1:0] opnd;
  logic                  is_rem;
  logic                  accept;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] c_res;
  logic [DATA_WIDTH-1:0] c_hi;
  logic                  c_ovf;
  logic                  c_err;
  logic                  go_mul;
  logic                  go_div;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_hi;
  logic [DATA_WIDTH-1:0] mul_lo;
  logic [DATA_WIDTH:0]   div_sh;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_sub;
  logic [DATA_WIDTH-1:0] div_hi;
  logic [DATA_WIDTH-1:0] div_lo;

  // rst_done keeps in_ready low while reset is asserted, although the state is already IDLE
  assign in_ready = rst_done && (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign sum  = op1 + op2;
  assign diff = op1 - op2;

  always_comb begin
    c_res  = '0;
    c_hi   = '0;
    c_ovf  = 1'b0;
    c_err  = 1'b0;
    go_mul = 1'b0;
    go_div = 1'b0;
    case (oprn)
      OP_ADD: begin
        c_res = sum;
        c_ovf = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
      end
      OP_SUB: begin
        c_res = diff;
        c_ovf = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
      end
      OP_MUL: go_mul = 1'b1;
      OP_SHR: c_res = (op2 >= DW_V) ? '0 : (op1 >> op2[SHAMT_W-1:0]);
      OP_SHL: c_res = (op2 >= DW_V) ? '0 : (op1 << op2[SHAMT_W-1:0]);
      OP_AND: c_res = op1 & op2;
      OP_OR:  c_res = op1 | op2;
      OP_NOR: c_res = ~(op1 | op2);
      OP_SLT: c_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_DIV, OP_REM: begin
        if (DIV_ENABLE == 0) begin
          c_err = 1'b1;
        end else if (op2 == '0) begin
          // divide by zero resolves immediately: quotient all ones, remainder = dividend
          c_err = 1'b1;
          c_res = (oprn == OP_REM) ? op1 : '1;
          c_hi  = (oprn == OP_REM) ? '1 : op1;
        end else begin
          go_div = 1'b1;
        end
      end
      default: c_err = 1'b1;
    endcase
  end

  // One shift-add step: {carry, acc_hi, acc_lo} shifted right, multiplier consumed from acc_lo[0]
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi  = mul_sum[DATA_WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
  end

  // One restoring step: acc_hi holds the partial remainder, acc_lo shifts dividend out / quotient in
  always_comb begin
    div_sh  = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd});
    div_sub = div_sh[DATA_WIDTH-1:0] - opnd;
    div_hi  = div_ge ? div_sub : div_sh[DATA_WIDTH-1:0];
    div_lo  = {acc_lo[DATA_WIDTH-2:0], div_ge};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      rst_done  <= 1'b0;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      is_rem    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (go_mul || go_div) begin
              state  <= go_mul ? S_MUL : S_DIV;
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= op1;
              opnd   <= op2;
              is_rem <= (oprn == OP_REM);
            end else begin
              out_valid <= 1'b1;
              result    <= c_res;
              result_hi <= c_hi;
              zero      <= (c_res == '0);
              ovf       <= c_ovf;
              err       <= c_err;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi;
          acc_lo <= mul_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            result    <= mul_lo;
            result_hi <= mul_hi;
            zero      <= (mul_lo == '0);
            ovf       <= (mul_hi != '0);
            err       <= 1'b0;
          end
        end
        S_DIV: begin
          acc_hi <= div_hi;
          acc_lo <= div_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            result    <= is_rem ? div_hi : div_lo;
            result_hi <= is_rem ? div_lo : div_hi;
            zero      <= ((is_rem ? div_hi : div_lo) == '0);
            ovf       <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Table-driven bench for alu_mc: 32-bit, 8-bit and divide-disabled instances share operand buses,
// each with its own in_valid, plus hand sequences for backpressure and mid-operation reset.
module tb_alu_mc;

  localparam logic [5:0] OP_ADD = 6'h01, OP_SUB = 6'h02, OP_MUL = 6'h03, OP_SHR = 6'h04;
  localparam logic [5:0] OP_SHL = 6'h05, OP_AND = 6'h06, OP_OR  = 6'h07, OP_NOR = 6'h08;
  localparam logic [5:0] OP_SLT = 6'h09, OP_DIV = 6'h0A, OP_REM = 6'h0B;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic        out_ready_i;
  logic [31:0] op1_i, op2_i;
  logic [5:0]  oprn_i;

  logic        ir0, ov0, z0, v0, e0;
  logic [31:0] r0, h0;
  logic        ir1, ov1, z1, v1, e1;
  logic [7:0]  r1, h1;
  logic        ir2, ov2, z2, v2, e2;
  logic [31:0] r2, h2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mc u_w32 (
    .CLK(clk), .RST(rst), .in_valid(iv[0]), .in_ready(ir0),
    .op1(op1_i), .op2(op2_i), .oprn(oprn_i),
    .out_valid(ov0), .out_ready(out_ready_i),
    .result(r0), .result_hi(h0), .zero(z0), .ovf(v0), .err(e0)
  );

  alu_mc #(.DATA_WIDTH(8)) u_w8 (
    .CLK(clk), .RST(rst), .in_valid(iv[1]), .in_ready(ir1),
    .op1(op1_i[7:0]), .op2(op2_i[7:0]), .oprn(oprn_i),
    .out_valid(ov1), .out_ready(out_ready_i),
    .result(r1), .result_hi(h1), .zero(z1), .ovf(v1), .err(e1)
  );

  alu_mc #(.DIV_ENABLE(0)) u_nodiv (
    .CLK(clk), .RST(rst), .in_valid(iv[2]), .in_ready(ir2),
    .op1(op1_i), .op2(op2_i), .oprn(oprn_i),
    .out_valid(ov2), .out_ready(out_ready_i),
    .result(r2), .result_hi(h2), .zero(z2), .ovf(v2), .err(e2)
  );

  typedef struct packed {
    logic        rdy;
    logic        val;
    logic        z;
    logic        v;
    logic        e;
    logic [31:0] r;
    logic [31:0] h;
  } obs_t;

  obs_t ob [3];

  always_comb begin
    ob[0] = {ir0, ov0, z0, v0, e0, r0, h0};
    ob[1] = {ir1, ov1, z1, v1, e1, 24'h0, r1, 24'h0, h1};
    ob[2] = {ir2, ov2, z2, v2, e2, r2, h2};
  end

  typedef struct {
    int          sel;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        v;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vt[$];

  function automatic void vec(input int sel, input logic [5:0] op, input logic [31:0] a, b, r, h,
                              input logic z, v, e, input int lat);
    vec_t t;
    t.sel = sel; t.op = op; t.a = a; t.b = b; t.r = r; t.h = h;
    t.z = z; t.v = v; t.e = e; t.lat = lat;
    vt.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic expired(input string nm, input int idx);
    total++;
    bad++;
    $display("FAIL %s[%0d] wait bound expired", nm, idx);
  endtask

  // Present one op to instance sel, wait for acceptance, then drop in_valid just after the edge.
  task automatic issue(input int sel, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    @(negedge clk);
    op1_i = a; op2_i = b; oprn_i = op;
    iv = '0; iv[sel] = 1'b1;
    g = 0;
    while (ob[sel].rdy !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (ob[sel].rdy !== 1'b1) expired("accept", sel);
    @(posedge clk);
    #1;
    iv = '0;
  endtask

  task automatic run(input int idx, input vec_t t);
    int   lat;
    int   busy_rdy;
    obs_t o;
    out_ready_i = 1'b1;
    issue(t.sel, t.op, t.a, t.b);
    lat = 0;
    busy_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ob[t.sel].val !== 1'b1 && ob[t.sel].rdy !== 1'b0) busy_rdy++;
    end while (ob[t.sel].val !== 1'b1 && lat < 100);
    if (ob[t.sel].val !== 1'b1) expired("out_valid", idx);
    o = ob[t.sel];
    chk("latency",    idx, lat,      t.lat);
    chk("busy_ready", idx, busy_rdy, 0);
    chk("result",     idx, o.r,      t.r);
    chk("result_hi",  idx, o.h,      t.h);
    chk("zero",       idx, o.z,      t.z);
    chk("ovf",        idx, o.v,      t.v);
    chk("err",        idx, o.e,      t.e);
  endtask

  // Hold a result under backpressure, then drain and accept in the same cycle at full rate.
  task automatic stall_seq(input int sel);
    int          unstable;
    int          rdy_seen;
    logic [5:0]  bop [4];
    logic [31:0] ba  [4];
    logic [31:0] bb  [4];
    logic [31:0] bexp[4];
    bop = '{OP_AND, OP_ADD, OP_SUB, OP_OR};
    ba  = '{32'd3, 32'd10, 32'd9, 32'd8};
    bb  = '{32'd1, 32'd20, 32'd4, 32'd1};
    bexp = '{32'd1, 32'd30, 32'd5, 32'd9};
    out_ready_i = 1'b0;
    issue(sel, OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    chk("stall_valid",  sel, ob[sel].val, 1'b1);
    chk("stall_result", sel, ob[sel].r,   32'd5);
    unstable = 0;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ob[sel].val !== 1'b1 || ob[sel].r !== 32'd5) unstable++;
      if (ob[sel].rdy !== 1'b0) rdy_seen++;
    end
    chk("stall_hold",  sel, unstable, 0);
    chk("stall_ready", sel, rdy_seen, 0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op1_i = ba[i]; op2_i = bb[i]; oprn_i = bop[i];
      iv = '0; iv[sel] = 1'b1;
      #1;
      chk("b2b_ready", sel * 10 + i, ob[sel].rdy, 1'b1);
      @(negedge clk);
      chk("b2b_valid",  sel * 10 + i, ob[sel].val, 1'b1);
      chk("b2b_result", sel * 10 + i, ob[sel].r,   bexp[i]);
    end
    iv = '0;
  endtask

  // Abort a multiply with reset after k busy cycles, then confirm normal operation resumes.
  task automatic reset_seq(input int sel, input int k);
    vec_t t;
    out_ready_i = 1'b1;
    issue(sel, OP_MUL, 32'hFFFF_FFFF, 32'd2);
    repeat (k) @(negedge clk);
    chk("midop_valid", sel, ob[sel].val, 1'b0);
    chk("midop_ready", sel, ob[sel].rdy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid",  sel, ob[sel].val, 1'b0);
    chk("abort_ready",  sel, ob[sel].rdy, 1'b0);
    chk("abort_result", sel, ob[sel].r,   32'd0);
    chk("abort_hi",     sel, ob[sel].h,   32'd0);
    chk("abort_flags",  sel, {ob[sel].z, ob[sel].v, ob[sel].e}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("rearm_ready", sel, ob[sel].rdy, 1'b1);
    t.sel = sel; t.op = OP_ADD; t.a = 32'd2; t.b = 32'd3; t.r = 32'd5; t.h = 32'd0;
    t.z = 1'b0; t.v = 1'b0; t.e = 1'b0; t.lat = 1;
    run(200 + sel, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv = '0; out_ready_i = 1'b1;
    op1_i = '0; op2_i = '0; oprn_i = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_valid",  s, ob[s].val, 1'b0);
      chk("rst_ready",  s, ob[s].rdy, 1'b0);
      chk("rst_result", s, ob[s].r,   32'd0);
      chk("rst_hi",     s, ob[s].h,   32'd0);
      chk("rst_flags",  s, {ob[s].z, ob[s].v, ob[s].e}, 3'b000);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk("ready_after_rst", s, ob[s].rdy, 1'b1);

    //  sel op      a              b              result         result_hi      z     v     e     lat
    vec(0, OP_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b1, 1'b0, 1);
    vec(0, OP_MUL, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 32'h1,         1'b0, 1'b1, 1'b0, 33);
    vec(0, OP_DIV, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 1'b0, 33);
    vec(0, OP_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b0, 1'b0, 1'b1, 1);
    vec(0, OP_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(0, OP_SHL, 32'd1,         32'd32,        32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(0, OP_SHR, 32'h8000_0000, 32'd31,        32'd1,         32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(0, 6'h3F,  32'd7,         32'd9,         32'd0,         32'h0,         1'b1, 1'b0, 1'b1, 1);
    vec(0, OP_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0, 1);
    vec(0, OP_SUB, 32'd5,         32'd5,         32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(0, OP_REM, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0, 1'b0, 33);
    vec(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(0, OP_OR,  32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(0, OP_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(0, OP_NOR, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(0, OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'h1,         1'b1, 1'b1, 1'b0, 33);
    vec(0, OP_MUL, 32'd12345,     32'd1000,      32'h00BC_5EA8, 32'h0,         1'b0, 1'b0, 1'b0, 33);
    vec(0, OP_REM, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1);
    vec(0, OP_DIV, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         1'b0, 1'b0, 1'b0, 33);
    vec(0, OP_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(0, OP_SHL, 32'd3,         32'd4,         32'h30,        32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(0, OP_SHR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(0, OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(0, 6'h00,  32'd1,         32'd1,         32'd0,         32'h0,         1'b1, 1'b0, 1'b1, 1);
    vec(0, 6'h0C,  32'd1,         32'd1,         32'd0,         32'h0,         1'b1, 1'b0, 1'b1, 1);
    vec(1, OP_ADD, 32'h7F,        32'h01,        32'h80,        32'h0,         1'b0, 1'b1, 1'b0, 1);
    vec(1, OP_MUL, 32'hFF,        32'h02,        32'hFE,        32'h01,        1'b0, 1'b1, 1'b0, 9);
    vec(1, OP_DIV, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 1'b0, 9);
    vec(1, OP_DIV, 32'd5,         32'd0,         32'hFF,        32'd5,         1'b0, 1'b0, 1'b1, 1);
    vec(1, OP_SLT, 32'hFF,        32'h01,        32'd1,         32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(1, OP_SHL, 32'd1,         32'd8,         32'd0,         32'h0,         1'b1, 1'b0, 1'b0, 1);
    vec(1, OP_SHR, 32'h80,        32'd7,         32'd1,         32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(1, 6'h3F,  32'd1,         32'd1,         32'd0,         32'h0,         1'b1, 1'b0, 1'b1, 1);
    vec(1, OP_MUL, 32'hFF,        32'hFF,        32'h01,        32'hFE,        1'b0, 1'b1, 1'b0, 9);
    vec(1, OP_REM, 32'hFF,        32'h10,        32'h0F,        32'h0F,        1'b0, 1'b0, 1'b0, 9);
    vec(2, OP_DIV, 32'd100,       32'd7,         32'd0,         32'h0,         1'b1, 1'b0, 1'b1, 1);
    vec(2, OP_REM, 32'd100,       32'd7,         32'd0,         32'h0,         1'b1, 1'b0, 1'b1, 1);
    vec(2, OP_ADD, 32'd2,         32'd3,         32'd5,         32'h0,         1'b0, 1'b0, 1'b0, 1);
    vec(2, OP_MUL, 32'd3,         32'd4,         32'd12,        32'h0,         1'b0, 1'b0, 1'b0, 33);

    for (int i = 0; i < vt.size(); i++) run(i, vt[i]);

    stall_seq(0);
    stall_seq(1);
    reset_seq(0, 10);
    reset_seq(1, 5);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
